// File: rtl/pie_rx_decoder.sv
// PIE receive front end: delimiter detect, Tari/RTcal/TRcal capture and data-bit slicing.
// Optional build macro PIE_GLITCH_FILT_EN inserts a GLITCH_LEN-cycle glitch filter after the synchronizer.
module pie_rx_decoder #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DELIM_MIN  = 560,
    parameter int unsigned DELIM_MAX  = 720,
    parameter int unsigned GLITCH_LEN = 4
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             rd_data,
    output logic             bit_vld,
    output logic             bit_dat,
    output logic             frm_start,
    output logic             preamble,
    output logic [CNT_W-1:0] tari,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal,
    output logic             frm_end,
    output logic             frm_err
);
    typedef enum logic [2:0] {IDLE, DATA0, RTCAL, TRDAT, DATA} state_t;

    localparam int unsigned      XW      = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             rd_meta;
    logic             rd_sync;
    logic             line;
    logic             line_d;
    logic             rise;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] iv_cnt;
    logic             delim_ok;
    logic             bit_dec;
    logic             rt_ok;
    logic             tr_tmo;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            rd_meta <= 1'b0;
            rd_sync <= 1'b0;
        end else begin
            rd_meta <= rd_data;
            rd_sync <= rd_meta;
        end
    end

`ifdef PIE_GLITCH_FILT_EN
    localparam int unsigned GW = $clog2(GLITCH_LEN + 1);

    logic          filt;
    logic [GW-1:0] g_cnt;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            filt  <= 1'b0;
            g_cnt <= '0;
        end else if (rd_sync == filt) begin
            g_cnt <= '0;
        end else if (g_cnt == GW'(GLITCH_LEN - 1)) begin
            filt  <= rd_sync;
            g_cnt <= '0;
        end else begin
            g_cnt <= g_cnt + 1'b1;
        end
    end

    always_comb line = filt;
`else
    always_comb line = rd_sync;
`endif

    // rise is registered so it lines up with the first high cycle of line_d
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            line_d  <= 1'b0;
            rise    <= 1'b0;
            low_cnt <= '0;
            iv_cnt  <= '0;
        end else begin
            line_d <= line;
            rise   <= line & ~line_d;
            if (rise)
                low_cnt <= '0;
            else if (!line_d && low_cnt != CNT_MAX)
                low_cnt <= low_cnt + 1'b1;
            // the rise cycle itself is the first cycle of the new interval, so N cycles read as N
            if (rise)
                iv_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (iv_cnt != CNT_MAX)
                iv_cnt <= iv_cnt + 1'b1;
        end
    end

    always_comb begin
        delim_ok = (low_cnt >= CNT_W'(DELIM_MIN)) && (low_cnt <= CNT_W'(DELIM_MAX));
        bit_dec  = iv_cnt > (rtcal >> 1);
        rt_ok    = (XW'(iv_cnt) >= (XW'(tari) << 1)) && (XW'(iv_cnt) <= (XW'(tari) << 2));
        tr_tmo   = XW'(iv_cnt) >= (XW'(rtcal) << 2);
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_vld   <= 1'b0;
            bit_dat   <= 1'b0;
            frm_start <= 1'b0;
            preamble  <= 1'b0;
            tari      <= '0;
            rtcal     <= '0;
            trcal     <= '0;
            frm_end   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            bit_vld   <= 1'b0;
            frm_start <= 1'b0;
            frm_end   <= 1'b0;
            frm_err   <= 1'b0;
            if (rise && delim_ok && state != IDLE) begin
                frm_err <= 1'b1;
                state   <= DATA0;
            end else begin
                unique case (state)
                    IDLE: if (rise && delim_ok) state <= DATA0;
                    DATA0: if (rise) begin
                        tari  <= iv_cnt;
                        state <= RTCAL;
                    end
                    RTCAL: if (rise) begin
                        if (rt_ok) begin
                            rtcal     <= iv_cnt;
                            frm_start <= 1'b1;
                            state     <= TRDAT;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    TRDAT: if (rise) begin
                        if (iv_cnt > rtcal) begin
                            trcal    <= iv_cnt;
                            preamble <= 1'b1;
                        end else begin
                            trcal    <= '0;
                            preamble <= 1'b0;
                            bit_vld  <= 1'b1;
                            bit_dat  <= bit_dec;
                        end
                        state <= DATA;
                    end else if (tr_tmo) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end
                    DATA: if (rise) begin
                        bit_vld <= 1'b1;
                        bit_dat <= bit_dec;
                    end else if (iv_cnt >= rtcal) begin
                        frm_end <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pie_rx_decoder.sv
// Randomized and directed bench for pie_rx_decoder; expectations come from frame-level rules
// applied to the symbol lengths the bench itself generates.
`timescale 1ns/1ps
module tb_pie_rx_decoder;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned GLITCH_LEN = 4;
`ifdef PIE_GLITCH_FILT_EN
    localparam int unsigned LAT = 4 + GLITCH_LEN;
`else
    localparam int unsigned LAT = 4;
`endif

    logic             clk_50m = 1'b0;
    logic             rst_n;
    logic             rd_data;
    logic             bit_vld;
    logic             bit_dat;
    logic             frm_start;
    logic             preamble;
    logic [CNT_W-1:0] tari;
    logic [CNT_W-1:0] rtcal;
    logic [CNT_W-1:0] trcal;
    logic             frm_end;
    logic             frm_err;

    pie_rx_decoder #(
        .CNT_W      (CNT_W),
        .DELIM_MIN  (560),
        .DELIM_MAX  (720),
        .GLITCH_LEN (GLITCH_LEN)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rd_data   (rd_data),
        .bit_vld   (bit_vld),
        .bit_dat   (bit_dat),
        .frm_start (frm_start),
        .preamble  (preamble),
        .tari      (tari),
        .rtcal     (rtcal),
        .trcal     (trcal),
        .frm_end   (frm_end),
        .frm_err   (frm_err)
    );

    always #10 clk_50m = ~clk_50m;

    int unsigned cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    logic        got_bits[$];
    int unsigned n_start = 0, n_end = 0, n_err = 0, n_viol = 0;
    int unsigned start_cyc = 0, end_cyc = 0, vld_cyc = 0;

    always @(negedge clk_50m) begin
        if (bit_vld) begin
            got_bits.push_back(bit_dat);
            vld_cyc = cyc;
        end
        if (frm_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (frm_end) begin
            n_end++;
            end_cyc = cyc;
        end
        if (frm_err) n_err++;
        if ((frm_end && frm_err) || (frm_end && bit_vld)) n_viol++;
    end

    int unsigned n_cmp = 0, n_mis = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int unsigned n);
        rd_data = lvl;
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    // one PIE symbol: high part then a low pulse of pw; the next rise closes it
    task automatic sym(input int unsigned len, input int unsigned pw);
        hold(1'b1, len - pw);
        hold(1'b0, pw);
    endtask

    int unsigned sym_q[$];

    task automatic run_frame(input int unsigned dl, input int unsigned t, input int unsigned r,
                             input int unsigned tr, input int unsigned pw, input int unsigned glitch_at);
        int unsigned s_st, s_en, s_er, b0, rise_c;
        logic        exp_bits[$];
        bit          ok_delim, ok_rt, good;
        s_st = n_start; s_en = n_end; s_er = n_err; b0 = got_bits.size();
        ok_delim = (dl >= 560) && (dl <= 720);
        ok_rt    = (r >= 2 * t) && (r <= 4 * t);
        good     = ok_delim && ok_rt;
        if (good)
            foreach (sym_q[i]) exp_bits.push_back(sym_q[i] * 2 > r);
        hold(1'b0, dl);
        sym(t, pw);
        sym(r, pw);
        rise_c = cyc;
        if (tr != 0) sym(tr, pw);
        foreach (sym_q[i]) sym(sym_q[i], pw);
        if (glitch_at != 0) begin
            hold(1'b1, glitch_at);
            hold(1'b0, 2);
        end
        hold(1'b1, r + 50);
        check_eq("frm_start_cnt", longint'(n_start - s_st), good ? 1 : 0);
        check_eq("frm_err_cnt", longint'(n_err - s_er), (ok_delim && !ok_rt) ? 1 : 0);
        check_eq("frm_end_cnt", longint'(n_end - s_en), good ? 1 : 0);
        check_eq("bit_count", longint'(got_bits.size() - b0), longint'(exp_bits.size()));
        foreach (exp_bits[i])
            if (b0 + i < got_bits.size())
                check_eq("bit_dat", longint'(got_bits[b0 + i]), longint'(exp_bits[i]));
        if (good) begin
            check_eq("tari", longint'(tari), longint'(t));
            check_eq("rtcal", longint'(rtcal), longint'(r));
            check_eq("trcal", longint'(trcal), longint'(tr));
            check_eq("preamble", longint'(preamble), (tr != 0) ? 1 : 0);
            check_eq("start_latency", longint'(start_cyc - rise_c), longint'(LAT));
            check_eq("end_latency", longint'(end_cyc - vld_cyc), longint'(r));
        end
    endtask

    initial begin
        int unsigned s_st, s_en, s_er, b0;
        int unsigned t, r, tr, dl, nb;
        rst_n   = 1'b0;
        rd_data = 1'b1;
        repeat (5) @(posedge clk_50m);
        #1;
        check_eq("reset_flags", longint'({bit_vld, bit_dat, frm_start, preamble, frm_end, frm_err}), 0);
        check_eq("reset_counts", longint'({tari, rtcal, trcal}), 0);
        rst_n = 1'b1;
        hold(1'b1, 100);

        sym_q = '{1000, 625, 1000, 1000};
        run_frame(625, 625, 1625, 0, 156, 0);
        run_frame(625, 625, 1625, 4000, 156, 0);

        sym_q = '{800, 801};
        run_frame(625, 625, 1600, 0, 156, 0);

        sym_q = '{1000};
        run_frame(500, 625, 1625, 0, 156, 0);
        sym_q = '{400};
        run_frame(721, 200, 500, 0, 50, 0);
        sym_q = '{625};
        run_frame(625, 625, 1000, 0, 156, 0);

        // delimiter-length low inside DATA restarts the frame
        s_st = n_start; s_en = n_end; s_er = n_err; b0 = got_bits.size();
        hold(1'b0, 625);
        sym(625, 156); sym(1625, 156); sym(1000, 156); sym(625, 156);
        sym(825, 625);
        sym(625, 156);
        check_eq("restart_err", longint'(n_err - s_er), 1);
        check_eq("restart_no_end", longint'(n_end - s_en), 0);
        sym(1625, 156); sym(625, 156); sym(1000, 156);
        hold(1'b1, 1675);
        check_eq("restart_starts", longint'(n_start - s_st), 2);
        check_eq("restart_errs", longint'(n_err - s_er), 1);
        check_eq("restart_ends", longint'(n_end - s_en), 1);
        check_eq("restart_bits", longint'(got_bits.size() - b0), 4);
        if (got_bits.size() - b0 == 4) begin
            check_eq("restart_b0", longint'(got_bits[b0]), 1);
            check_eq("restart_b1", longint'(got_bits[b0 + 1]), 0);
            check_eq("restart_b2", longint'(got_bits[b0 + 2]), 0);
            check_eq("restart_b3", longint'(got_bits[b0 + 3]), 1);
        end

        // reset in the middle of DATA
        b0 = got_bits.size();
        hold(1'b0, 625);
        sym(625, 156); sym(1625, 156); sym(1000, 156); sym(625, 156);
        hold(1'b1, 300);
        check_eq("pre_rst_tari", longint'(tari), 625);
        check_eq("pre_rst_bits", longint'(got_bits.size() - b0), 2);
        rst_n = 1'b0;
        @(posedge clk_50m);
        #1;
        check_eq("rst_flags", longint'({bit_vld, bit_dat, frm_start, preamble, frm_end, frm_err}), 0);
        check_eq("rst_counts", longint'({tari, rtcal, trcal}), 0);
        rst_n = 1'b1;
        s_st = n_start; s_en = n_end; s_er = n_err;
        hold(1'b1, 2000);
        check_eq("post_rst_end", longint'(n_end - s_en), 0);
        check_eq("post_rst_events", longint'((n_start - s_st) + (n_err - s_er)), 0);

`ifdef PIE_GLITCH_FILT_EN
        sym_q = '{1000, 625};
        run_frame(625, 625, 1625, 0, 156, 300);
`endif

        for (int f = 0; f < 3; f++) begin
            t  = $urandom_range(300, 200);
            r  = t * 5 / 2 + $urandom_range(t * 2 / 5, 0);
            dl = (f == 0) ? 560 : (f == 1) ? 720 : $urandom_range(720, 560);
            tr = ($urandom_range(1, 0) == 1) ? r + r / 10 + $urandom_range(r * 9 / 10, 0) : 0;
            nb = $urandom_range(4, 1);
            sym_q.delete();
            for (int b = 0; b < int'(nb); b++)
                sym_q.push_back(($urandom_range(1, 0) == 1) ? t * 3 / 2 + $urandom_range(t / 2, 1) : t);
            run_frame(dl, t, r, tr, t / 4, 0);
        end

        check_eq("exclusive_pulses", longint'(n_viol), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
